// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FWFT FIFO and its bench.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  // Pointer width for a given depth: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage array, one synchronous write port, one async read port.
// Latency: write lands on the rising edge; read is combinational from stored state.
// Backpressure: none; the caller gates we.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Store the write word; the array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO between a same-domain producer and consumer.
// Latency: a word written into an empty FIFO is on data_out right after the accepting edge.
// Backpressure: writes while full and reads while empty are silently dropped.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int              PTR_W   = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Flags come purely from the registered pointers, so they are glitch-free
  // relative to this cycle's requests.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                    (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  // Advance each pointer when its side is accepted; wrap bit rolls over naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (w_rdata)
  );

  // Stale array contents are masked whenever nothing is stored.
  assign data_out = w_empty ? '0 : w_rdata;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: queue-based reference model plus directed and random traffic.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DW    = DEFAULT_DATA_WIDTH;
  localparam int DEPTH = DEFAULT_DEPTH;
  localparam int CW    = ptr_width(DEPTH);
  localparam int NRND  = 60;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: contents of the FIFO, oldest first.
  logic [DW-1:0] ref_q[$];
  bit            rnd_on  = 1'b0;
  int            rnd_pops = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
  endtask

  // Model update on each edge from the requests in force before that edge.
  always @(posedge clk) begin
    if (rst_n) begin
      bit do_wr;
      bit do_rd;
      do_wr = wr_en && (ref_q.size() < DEPTH);
      do_rd = rd_en && (ref_q.size() > 0);
      if (do_rd) void'(ref_q.pop_front());
      if (do_wr) ref_q.push_back(data_in);
    end
  end

  // Reset discards everything logically, at any time.
  always @(negedge rst_n) ref_q.delete();

  // Monitor: compare presented outputs against the model away from the active edge.
  always @(negedge clk) begin
    int sz;
    sz = ref_q.size();
    chk("mon_empty", int'(empty), int'(sz == 0));
    chk("mon_full", int'(full), int'(sz == DEPTH));
    chk("mon_count", int'(count), sz);
    chk("mon_data_out", int'(data_out), (sz > 0) ? int'(ref_q[0]) : 0);
    if (rnd_on && rd_en && !empty) rnd_pops++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input int e_empty, input int e_full,
                           input int e_count, input int e_dout);
    chk({nm, "_empty"}, int'(empty), e_empty);
    chk({nm, "_full"}, int'(full), e_full);
    chk({nm, "_count"}, int'(count), e_count);
    chk({nm, "_data_out"}, int'(data_out), e_dout);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_state("reset", 1, 0, 0, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk_state("idle_read", 1, 0, 0, 0);

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h11 + i); tick();
      chk("fill_head", int'(data_out), 'h11);
    end
    chk_state("filled", 0, 1, 8, 'h11);
    data_in = 8'hFF; tick(); wr_en = 1'b0;
    chk_state("write_when_full", 0, 1, 8, 'h11);

    // Drain in order.
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", int'(data_out), 'h11 + i);
      tick();
    end
    chk_state("drained", 1, 0, 0, 0);
    tick(); rd_en = 1'b0;
    chk_state("read_when_empty", 1, 0, 0, 0);

    // Simultaneous read/write at count 3.
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin data_in = DW'(8'h21 + i); tick(); end
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = DW'(8'h24 + i);
      chk("simul_order", int'(data_out), 'h21 + i);
      tick();
      chk("simul_count", int'(count), 3);
    end
    rd_en = 1'b0;
    chk("simul_head", int'(data_out), 'h26);

    // Simultaneous read/write while full: write rejected.
    for (int i = 0; i < 5; i++) begin data_in = DW'(8'h29 + i); tick(); end
    chk("refill_full", int'(full), 1);
    rd_en = 1'b1; data_in = 8'hEE; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("full_rw_count", int'(count), 7);
    chk("full_rw_head", int'(data_out), 'h27);
    rd_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("full_rw_order", int'(data_out), 'h27 + i);
      tick();
    end
    rd_en = 1'b0;
    chk("full_rw_discard_empty", int'(empty), 1);

    // Simultaneous read/write while empty: read rejected.
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hA5; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_state("empty_rw", 0, 0, 1, 'hA5);
    rd_en = 1'b1; tick(); rd_en = 1'b0;

    // Random wrap-around traffic.
    begin
      int wr_idx = 0;
      int cyc = 0;
      rnd_pops = 0;
      rnd_on = 1'b1;
      while ((wr_idx < NRND || ref_q.size() > 0) && cyc < 3000) begin
        wr_en = (cyc % 2 == 0) && (wr_idx < NRND) && !full;
        if (wr_en) begin
          data_in = DW'($urandom);
          wr_idx++;
        end
        rd_en = (cyc % 3 == 0);
        tick();
        cyc++;
      end
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      rnd_on = 1'b0;
      chk("rnd_finished_in_budget", int'(cyc < 3000), 1);
      chk("rnd_pops", rnd_pops, NRND);
      chk("rnd_wraps_ge3", int'(rnd_pops / DEPTH >= 3), 1);
    end

    // Mid-operation asynchronous reset.
    tick();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin data_in = DW'(8'h50 + i); tick(); end
    wr_en = 1'b0;
    chk("pre_reset_count", int'(count), 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_state("async_reset", 1, 0, 0, 0);
    #1 rst_n = 1'b1;
    tick();
    wr_en = 1'b1; data_in = 8'h3C; tick(); wr_en = 1'b0;
    chk_state("post_reset_write", 0, 0, 1, 'h3C);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-word-fall-through (FWFT) FIFO used as a buffer between a producer and a consumer in the same clock domain. Data written with wr_en is stored in a register array. The oldest entry is always visible on data_out while the FIFO is non-empty. rd_en pops that entry. full and empty flags provide flow control.

Parameters:
DATA_WIDTH  8  width of each data word
DEPTH  8  number of entries; must be a power of two, >= 2
ADDR_WIDTH  $clog2(DEPTH)  derived; not to be overridden

Ports:
clk  input  1  sole clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
rd_en  input  1  read (pop) request
data_in  input  DATA_WIDTH  write data, sampled on clk rising edge when the write is accepted
data_out  output  DATA_WIDTH  head-of-queue data (FWFT)
full  output  1  high when DEPTH entries are stored
empty  output  1  high when 0 entries are stored
count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - wr_ptr, rd_ptr and count go to 0; empty=1; full=0; data_out=0.
  - Memory contents are not cleared. Prior contents are lost logically.
- Pointers are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit and the low ADDR_WIDTH bits index memory. Pointers wrap naturally modulo 2*DEPTH.
- Write accept condition: wr_en && !full.
  - On the clock edge, mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in and wr_ptr increments.
- Read accept condition: rd_en && !empty.
  - On the clock edge, rd_ptr increments.
- data_out = empty ? 0 : mem[rd_ptr[ADDR_WIDTH-1:0]]. It is a combinational read of registered state, so zero-latency FWFT.
  - The value to be consumed is valid in the same cycle rd_en is asserted.
- Write latency: a word written into an empty FIFO appears on data_out and empty deasserts one cycle after the accepting edge, i.e. immediately after that edge.
- Flags are derived from registered pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal && wrap bits differ).
  - count = wr_ptr - rd_ptr, truncated to ADDR_WIDTH+1 bits.
- Write while full: ignored. No pointer change, no memory change, no error output.
- Read while empty: ignored. data_out stays 0.
- Simultaneous write and read:
  - Not full and not empty: both are accepted; count is unchanged.
  - Full: read accepted, write rejected (full is evaluated before the edge); count becomes DEPTH-1.
  - Empty: write accepted, read rejected; count becomes 1.
- Ordering: strict first-in first-out, with no reordering or duplication across any number of wraps.

Decomposition:
- Package fifo_pkg:
  - DEFAULT_DATA_WIDTH=8 and DEFAULT_DEPTH=8 constants.
  - A ptr_t-style width constant helper used by the FIFO and its bench.
- One sub-module, fifo_mem:
  - DEPTH x DATA_WIDTH register array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
  - No reset on the array.
- Pointer, flag and count logic stays in sync_fifo.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release -> empty=1, full=0, count=0, data_out=0. A rd_en pulse leaves all of them unchanged.
- Fill to full: write 0x11..0x18 on 8 consecutive cycles -> full=1 and count=8 after the 8th edge. data_out=0x11 throughout. A 9th write of 0xFF is ignored and count stays 8.
- Drain in order: with rd_en held from full, data_out shows 0x11,0x12,...,0x18 on successive cycles. Afterwards empty=1 and data_out=0. An extra read leaves count at 0.
- Simultaneous ops:
  - At count=3, wr_en+rd_en for 5 cycles -> count stays 3 and the output sequence is preserved.
  - At full, wr_en+rd_en -> count=7 and the written word is discarded.
  - At empty, wr_en+rd_en with 0xA5 -> count=1 and data_out=0xA5.
- Wrap-around scoreboard:
  - Stimulus: 60 random words, writes on alternate cycles, reads on every third cycle, writes throttled by full.
  - Required: every popped word equals the scoreboard head, and the pointers wrap at least 3 times.
- Mid-operation reset: at count=5, pulse rst_n low between clock edges -> outputs reset immediately, asynchronously (empty=1, count=0, data_out=0). After release, writing 0x3C gives data_out=0x3C and count=1.
